// File: rtl/alu_pkg.sv
// alu_pkg: op codes, sequencer states and per-op helpers for the ALU host sequencer
package alu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    function automatic logic [1:0] byte_count(input logic [1:0] op);
        return (op == OP_DIV) ? 2'd3 : 2'd2;
    endfunction

    // mul/div return two result bytes; add/sub return one
    function automatic logic wide_result(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction
endpackage

// File: rtl/alu_timeout_timer.sv
// alu_timeout_timer: WAIT-phase watchdog, flags expiry at TIMEOUT_CYCLES-1
module alu_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMR_W = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign expired = cnt == TMR_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/alu_host_sequencer.sv
// alu_host_sequencer: valid/ready front end that loads the sequential ALU byte by byte
// and returns its reassembled result, with timeout and protocol-error recovery
module alu_host_sequencer
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_x,
    input  logic [7:0]  req_y,
    input  logic [7:0]  req_z,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_timeout,
    output logic        rsp_proto_err,
    output logic        alu_begin,
    output logic [1:0]  alu_op_code,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_end,
    output logic        alu_reset_out
);
    state_t      state;
    logic [1:0]  op, k, n;
    logic [7:0]  x, y, z, hist;
    logic [15:0] res;
    logic        tmo, perr, expired;

    alu_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TMR_W(TMR_W)) u_timer (
        .clk(clk),
        .reset(reset),
        .clear(state != WAIT),
        .enable(state == WAIT),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            op <= '0;
            k <= '0;
            n <= '0;
            x <= '0;
            y <= '0;
            z <= '0;
            hist <= '0;
            res <= '0;
            tmo <= 1'b0;
            perr <= 1'b0;
            alu_reset_out <= 1'b0;
        end else begin
            hist <= alu_outbus;
            alu_reset_out <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    op <= req_op;
                    x <= req_x;
                    y <= req_y;
                    z <= req_z;
                    n <= byte_count(req_op);
                    res <= '0;
                    tmo <= 1'b0;
                    perr <= 1'b0;
                    state <= START;
                end
                START, LOAD: if (alu_end) begin
                    perr <= 1'b1;
                    alu_reset_out <= 1'b1;
                    state <= RESP;
                end else if (state == START) begin
                    k <= '0;
                    state <= LOAD;
                end else if (k == n - 2'd1) begin
                    state <= WAIT;
                end else begin
                    k <= k + 2'd1;
                end
                // alu_end takes priority over a coincident expiry
                WAIT: if (alu_end) begin
                    res <= wide_result(op) ? {hist, alu_outbus} : {8'h00, alu_outbus};
                    state <= RESP;
                end else if (expired) begin
                    tmo <= 1'b1;
                    alu_reset_out <= 1'b1;
                    state <= RESP;
                end
                RESP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready     = state == IDLE;
    assign rsp_valid     = state == RESP;
    assign rsp_result    = rsp_valid ? res : 16'h0000;
    assign rsp_timeout   = rsp_valid & tmo;
    assign rsp_proto_err = rsp_valid & perr;
    assign alu_begin     = state == START;
    assign alu_op_code   = (state == IDLE) ? 2'b00 : op;
    assign alu_inbus     = (state != LOAD) ? 8'h00 : (k == 2'd0) ? x : (k == 2'd1) ? y : z;
endmodule

// File: tb/tb_alu_host_sequencer.sv
// tb_alu_host_sequencer: directed and randomized checks against an arithmetic reference model
module tb_alu_host_sequencer;
    logic        clk = 1'b0;
    logic        reset, req_valid, rsp_ready, alu_end;
    logic [1:0]  req_op;
    logic [7:0]  req_x, req_y, req_z, alu_outbus;
    logic        req_ready, rsp_valid, rsp_timeout, rsp_proto_err, alu_begin, alu_reset_out;
    logic [15:0] rsp_result;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_inbus;
    int checks = 0;
    int errors = 0;

    alu_host_sequencer #(.TIMEOUT_CYCLES(16), .TMR_W(10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_timeout(rsp_timeout), .rsp_proto_err(rsp_proto_err),
        .alu_begin(alu_begin), .alu_op_code(alu_op_code), .alu_inbus(alu_inbus),
        .alu_outbus(alu_outbus), .alu_end(alu_end), .alu_reset_out(alu_reset_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [15:0] dvd, dvs, q, r, s;
        dvd = {a, b};
        dvs = {8'h00, c};
        s = (op == 2'd0) ? {8'h00, a} + {8'h00, b} : {8'h00, a} - {8'h00, b};
        if (op == 2'd2) return {8'h00, a} * {8'h00, b};
        if (op == 2'd3) begin
            q = dvd / dvs;
            r = dvd % dvs;
            return {r[7:0], q[7:0]};
        end
        return {8'h00, s[7:0]};
    endfunction

    // full transaction: ALU answers d WAIT cycles after load, consumer stalls hold cycles
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int d, input int hold);
        logic [15:0] expv, alu_val;
        logic [7:0]  got [3];
        int n;
        expv = ref_result(op, a, b, c);
        n = (op == 2'd3) ? 3 : 2;
        got[2] = 8'h00;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1; req_op = op; req_x = a; req_y = b; req_z = c;
        @(negedge clk);
        req_valid = 0;
        check("begin_start", alu_begin, 1);
        check("op_code_start", alu_op_code, op);
        check("inbus_start", alu_inbus, 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("begin_low_load", alu_begin, 0);
            check("inbus_byte", alu_inbus, (i == 0) ? a : (i == 1) ? b : c);
            got[i] = alu_inbus;
        end
        alu_val = ref_result(alu_op_code, got[0], got[1], got[2]);
        alu_outbus = alu_val[15:8];
        for (int j = 0; j < d; j++) begin
            @(negedge clk);
            check("wait_no_rsp", rsp_valid, 0);
            if (j == d - 1) begin
                alu_outbus = alu_val[7:0];
                alu_end = 1;
            end
        end
        @(negedge clk);
        alu_end = 0;
        alu_outbus = 8'($urandom);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_result", rsp_result, expv);
        check("rsp_timeout_clr", rsp_timeout, 0);
        check("rsp_proto_clr", rsp_proto_err, 0);
        check("alu_reset_quiet", alu_reset_out, 0);
        check("op_code_held", alu_op_code, op);
        for (int h = 0; h < hold; h++) begin
            alu_end = 1'($urandom);
            @(negedge clk);
            check("rsp_hold_result", rsp_result, expv);
            check("rsp_hold_valid", rsp_valid, 1);
            check("req_ready_busy", req_ready, 0);
        end
        alu_end = 0;
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("rsp_released", rsp_valid, 0);
        check("op_code_idle", alu_op_code, 0);
    endtask

    initial begin
        logic [1:0] op;
        logic [7:0] a, b, c;
        reset = 1; req_valid = 0; rsp_ready = 0; alu_end = 0;
        req_op = 0; req_x = 0; req_y = 0; req_z = 0; alu_outbus = 0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_begin", alu_begin, 0);
        check("rst_inbus", alu_inbus, 0);
        check("rst_op_code", alu_op_code, 0);
        check("rst_result", rsp_result, 0);
        check("rst_alu_reset", alu_reset_out, 0);
        reset = 0;

        run_op(2'd0, 8'h12, 8'h34, 8'h00, 5, 0);
        run_op(2'd2, 8'h0F, 8'h03, 8'h00, 3, 2);
        run_op(2'd3, 8'h01, 8'h00, 8'h10, 4, 0);
        run_op(2'd1, 8'h10, 8'h20, 8'h00, 1, 1);
        run_op(2'd2, 8'hFF, 8'hFF, 8'h00, 16, 0);

        // watchdog: ALU never answers
        @(negedge clk);
        req_valid = 1; req_op = 2'd0; req_x = 8'h01; req_y = 8'h02;
        @(negedge clk);
        req_valid = 0;
        repeat (2) @(negedge clk);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            check("tmo_wait_no_rsp", rsp_valid, 0);
            check("tmo_wait_no_reset", alu_reset_out, 0);
        end
        @(negedge clk);
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_flag", rsp_timeout, 1);
        check("tmo_result", rsp_result, 0);
        check("tmo_proto", rsp_proto_err, 0);
        check("tmo_alu_reset", alu_reset_out, 1);
        @(negedge clk);
        check("tmo_alu_reset_pulse", alu_reset_out, 0);
        check("tmo_rsp_held", rsp_valid, 1);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;

        // protocol error: alu_end during first load byte
        req_valid = 1; req_op = 2'd2; req_x = 8'h55; req_y = 8'h66;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        alu_end = 1;
        @(negedge clk);
        alu_end = 0;
        check("perr_valid", rsp_valid, 1);
        check("perr_flag", rsp_proto_err, 1);
        check("perr_tmo", rsp_timeout, 0);
        check("perr_result", rsp_result, 0);
        check("perr_alu_reset", alu_reset_out, 1);
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            check("perr_hold_result", rsp_result, 0);
            check("perr_hold_flag", rsp_proto_err, 1);
            check("perr_req_ready", req_ready, 0);
            check("perr_reset_pulse", alu_reset_out, 0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;

        // reset during divide load
        req_valid = 1; req_op = 2'd3; req_x = 8'h02; req_y = 8'h03; req_z = 8'h40;
        @(negedge clk);
        req_valid = 0;
        repeat (2) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_inbus", alu_inbus, 0);
        check("mid_rst_rsp", rsp_valid, 0);
        check("mid_rst_begin", alu_begin, 0);
        check("mid_rst_alu_reset", alu_reset_out, 0);
        run_op(2'd0, 8'hF0, 8'h20, 8'h00, 2, 0);

        for (int t = 0; t < 30; t++) begin
            op = 2'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            c = 8'($urandom);
            if (op == 2'd3) begin
                c = 8'($urandom_range(1, 255));
                a = 8'($urandom_range(0, int'(c) - 1));
            end
            run_op(op, a, b, c, $urandom_range(1, 16), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
